// File: rtl/mux_pkg.sv
// Shared types and helpers for the scanning N:1 mux.
// Channel wrap is computed here so every user agrees on it.
package mux_pkg;

   typedef enum logic {
      MANUAL = 1'b0,
      SCAN   = 1'b1
   } mux_state_e;

   localparam int unsigned MUX_DEFAULT_DWELL = 50_000_000;

   // Next channel with wrap; never returns a value >= n.
   function automatic int unsigned mux_next_ch(
      input int unsigned cur,
      input int unsigned n
   );
      int unsigned inc;
      inc = cur + 1;
      return (inc >= n) ? 0 : inc;
   endfunction

endpackage

// File: rtl/mux_nto1_scan_dwell_counter.sv
// Dwell counter: counts 0..DWELL-1 while enabled.
// tick is high during the last count; clr wins over en.
module dwell_counter
   import mux_pkg::*;
#(
   parameter int unsigned DWELL = MUX_DEFAULT_DWELL
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      tick  = en && (cnt_q == LAST);
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tick ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mux_nto1_scan.sv
// Registered N:1 mux with latched select and auto-scan.
// Optional MUX_HOLD_EN adds a hold input that freezes data_out.
module mux_nto1_scan
   import mux_pkg::*;
#(
   parameter int unsigned WIDTH  = 1,
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned SEL_W  = $clog2(NUM_CH),
   parameter int unsigned DWELL  = MUX_DEFAULT_DWELL
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NUM_CH*WIDTH-1:0] data_in,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    load,
   input  logic                    scan,
`ifdef MUX_HOLD_EN
   input  logic                    hold,
`endif
   output logic [WIDTH-1:0]        data_out,
   output logic [SEL_W-1:0]        cur_ch,
   output logic                    ch_change,
   output logic                    sel_err
);

   mux_state_e       state_q, state_d;
   logic [SEL_W-1:0] cur_ch_q, cur_ch_d;
   logic             ch_change_q, ch_change_d;
   logic             sel_err_q, sel_err_d;
   logic [WIDTH-1:0] data_out_q, data_out_d;

   logic mode_chg;
   logic sel_ok;
   logic ld_ok;
   logic cnt_en;
   logic cnt_clr;
   logic tick;

   dwell_counter #(
      .DWELL (DWELL)
   ) u_dwell (
      .clock (clock),
      .reset (reset),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .tick  (tick)
   );

   always_comb begin
      state_d  = scan ? SCAN : MANUAL;
      mode_chg = (state_d != state_q);
      sel_ok   = (32'(sel) < NUM_CH);
      ld_ok    = load && sel_ok;
      // Scan advances only while staying in SCAN; a mode change resets dwell.
      cnt_en   = (state_q == SCAN) && !mode_chg;
      cnt_clr  = mode_chg || ld_ok;

      cur_ch_d = cur_ch_q;
      if (ld_ok) begin
         cur_ch_d = sel;
      end else if (tick) begin
         cur_ch_d = SEL_W'(mux_next_ch(32'(cur_ch_q), NUM_CH));
      end

      ch_change_d = (cur_ch_d != cur_ch_q);
      sel_err_d   = load && !sel_ok;

      data_out_d = '0;
      for (int k = 0; k < int'(NUM_CH); k++) begin
         if (cur_ch_q == SEL_W'(k)) begin
            data_out_d = data_in[k*WIDTH +: WIDTH];
         end
      end
`ifdef MUX_HOLD_EN
      if (hold) begin
         data_out_d = data_out_q;
      end
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= MANUAL;
         cur_ch_q    <= '0;
         ch_change_q <= 1'b0;
         sel_err_q   <= 1'b0;
         data_out_q  <= '0;
      end else begin
         state_q     <= state_d;
         cur_ch_q    <= cur_ch_d;
         ch_change_q <= ch_change_d;
         sel_err_q   <= sel_err_d;
         data_out_q  <= data_out_d;
      end
   end

   assign data_out  = data_out_q;
   assign cur_ch    = cur_ch_q;
   assign ch_change = ch_change_q;
   assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Directed-vector bench for mux_nto1_scan (5 ch x 4 bit, dwell 4).
// Expected outputs are queued per edge and checked by a monitor.
module tb_mux_nto1_scan;

   localparam int W  = 4;
   localparam int N  = 5;
   localparam int SW = 3;
   localparam int DW = 4;

   localparam logic [N*W-1:0] DF = 20'hFFFFF;
   localparam logic [N*W-1:0] D1 = 20'h5C3A6;
   localparam logic [N*W-1:0] D2 = 20'h5C3A9;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          load  = 1'b0;
   logic          scan  = 1'b0;
   logic [SW-1:0] sel   = '0;
   logic [N*W-1:0] data_in = '0;
`ifdef MUX_HOLD_EN
   logic          hold  = 1'b0;
`endif

   logic [W-1:0]  data_out;
   logic [SW-1:0] cur_ch;
   logic          ch_change;
   logic          sel_err;

   mux_nto1_scan #(
      .WIDTH  (W),
      .NUM_CH (N),
      .SEL_W  (SW),
      .DWELL  (DW)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .data_in   (data_in),
      .sel       (sel),
      .load      (load),
      .scan      (scan),
`ifdef MUX_HOLD_EN
      .hold      (hold),
`endif
      .data_out  (data_out),
      .cur_ch    (cur_ch),
      .ch_change (ch_change),
      .sel_err   (sel_err)
   );

   always #5 clock = ~clock;

   typedef struct {
      int            id;
      logic [SW-1:0] cur;
      logic          chg;
      logic          err;
      logic [W-1:0]  dout;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   vid    = 0;

   task automatic chk(input string nm, input int id,
                      input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL v%0d %s: got %0h want %0h", id, nm, got, want);
      end
   endtask

   task automatic drive(input logic r, input logic s, input logic l,
                        input logic [SW-1:0] sl, input logic [N*W-1:0] din,
                        input logic [SW-1:0] ecur, input logic echg,
                        input logic eerr, input logic [W-1:0] edout);
      exp_t e;
      reset   = r;
      scan    = s;
      load    = l;
      sel     = sl;
      data_in = din;
      e.id    = vid;
      e.cur   = ecur;
      e.chg   = echg;
      e.err   = eerr;
      e.dout  = edout;
      q.push_back(e);
      vid++;
   endtask

   task automatic step(input logic r, input logic s, input logic l,
                       input logic [SW-1:0] sl, input logic [N*W-1:0] din,
                       input logic [SW-1:0] ecur, input logic echg,
                       input logic eerr, input logic [W-1:0] edout);
      @(negedge clock);
      drive(r, s, l, sl, din, ecur, echg, eerr, edout);
   endtask

`ifdef MUX_HOLD_EN
   task automatic hstep(input logic h, input logic s,
                        input logic [N*W-1:0] din,
                        input logic [SW-1:0] ecur, input logic echg,
                        input logic [W-1:0] edout);
      @(negedge clock);
      hold = h;
      drive(1'b0, s, 1'b0, '0, din, ecur, echg, 1'b0, edout);
   endtask
`endif

   // Monitor: one expectation per edge, sampled 1 time unit after it.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("cur_ch",    e.id, 32'(cur_ch),    32'(e.cur));
            chk("ch_change", e.id, 32'(ch_change), 32'(e.chg));
            chk("sel_err",   e.id, 32'(sel_err),   32'(e.err));
            chk("data_out",  e.id, 32'(data_out),  32'(e.dout));
         end
      end
   end

   initial begin
      // reset with all-ones data, then release
      step(1, 0, 0, 0, DF, 0, 0, 0, 4'h0);
      step(1, 0, 0, 0, DF, 0, 0, 0, 4'h0);
      step(0, 0, 0, 0, DF, 0, 0, 0, 4'hF);
      step(0, 0, 0, 0, D1, 0, 0, 0, 4'h6);
      // manual loads, invalid selects, same-channel load
      step(0, 0, 1, 3, D1, 3, 1, 0, 4'h6);
      step(0, 0, 0, 0, D1, 3, 0, 0, 4'hC);
      step(0, 0, 1, 6, D1, 3, 0, 1, 4'hC);
      step(0, 0, 0, 0, D1, 3, 0, 0, 4'hC);
      step(0, 0, 1, 3, D1, 3, 0, 0, 4'hC);
      step(0, 0, 1, 5, D1, 3, 0, 1, 4'hC);
      step(0, 0, 1, 4, D1, 4, 1, 0, 4'hC);
      step(0, 0, 0, 0, D1, 4, 0, 0, 4'h5);
      // scan from channel 4: wraps 4 -> 0 -> 1
      step(0, 1, 0, 0, D1, 4, 0, 0, 4'h5);
      step(0, 1, 0, 0, D1, 4, 0, 0, 4'h5);
      step(0, 1, 0, 0, D1, 4, 0, 0, 4'h5);
      step(0, 1, 0, 0, D1, 4, 0, 0, 4'h5);
      step(0, 1, 0, 0, D1, 0, 1, 0, 4'h5);
      step(0, 1, 0, 0, D1, 0, 0, 0, 4'h6);
      step(0, 1, 0, 0, D1, 0, 0, 0, 4'h6);
      step(0, 1, 0, 0, D1, 0, 0, 0, 4'h6);
      step(0, 1, 0, 0, D1, 1, 1, 0, 4'h6);
      step(0, 1, 0, 0, D1, 1, 0, 0, 4'hA);
      step(0, 1, 0, 0, D1, 1, 0, 0, 4'hA);
      step(0, 1, 0, 0, D1, 1, 0, 0, 4'hA);
      // load on the dwell tick wins and restarts the dwell
      step(0, 1, 1, 3, D1, 3, 1, 0, 4'hA);
      step(0, 1, 0, 0, D1, 3, 0, 0, 4'hC);
      step(0, 1, 0, 0, D1, 3, 0, 0, 4'hC);
      step(0, 1, 0, 0, D1, 3, 0, 0, 4'hC);
      step(0, 1, 0, 0, D1, 4, 1, 0, 4'hC);
      // invalid load mid-scan leaves the dwell alone
      step(0, 1, 1, 7, D1, 4, 0, 1, 4'h5);
      step(0, 1, 0, 0, D1, 4, 0, 0, 4'h5);
      step(0, 1, 0, 0, D1, 4, 0, 0, 4'h5);
      step(0, 1, 0, 0, D1, 0, 1, 0, 4'h5);
      // leave scan together with a load
      step(0, 0, 1, 2, D1, 2, 1, 0, 4'h6);
      step(0, 0, 0, 0, D1, 2, 0, 0, 4'h3);
      step(0, 0, 0, 0, D1, 2, 0, 0, 4'h3);
      // enter scan together with a load
      step(0, 1, 1, 1, D1, 1, 1, 0, 4'h3);
      step(0, 1, 0, 0, D1, 1, 0, 0, 4'hA);
      step(0, 1, 0, 0, D1, 1, 0, 0, 4'hA);
      step(0, 1, 0, 0, D1, 1, 0, 0, 4'hA);
      step(0, 1, 0, 0, D1, 2, 1, 0, 4'hA);
      // reset mid-scan with a load pending, then fresh manual start
      step(1, 1, 1, 4, D1, 0, 0, 0, 4'h0);
      step(0, 0, 0, 0, D1, 0, 0, 0, 4'h6);
      step(0, 0, 0, 0, D2, 0, 0, 0, 4'h9);
      step(0, 0, 0, 0, D2, 0, 0, 0, 4'h9);
`ifdef MUX_HOLD_EN
      // hold while scanning: data_out frozen, cur_ch advances
      hstep(1, 1, D2, 0, 0, 4'h9);
      hstep(1, 1, D2, 0, 0, 4'h9);
      hstep(1, 1, D2, 0, 0, 4'h9);
      hstep(1, 1, D2, 0, 0, 4'h9);
      hstep(1, 1, D2, 1, 1, 4'h9);
      hstep(1, 1, D2, 1, 0, 4'h9);
      hstep(0, 1, D2, 1, 0, 4'hA);
      hstep(0, 1, D2, 1, 0, 4'hA);
`endif
      for (int i = 0; i < 10 && q.size() > 0; i++) begin
         @(posedge clock);
      end
      #2;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
